// File: rtl/tri_feeder_pkg.sv
// rtl/tri_feeder_pkg.sv - shared widths and state type for the triangle feeder
package tri_feeder_pkg;

    localparam int D_BITS_DEF = 32;
    localparam int M_BITS_DEF = 32;
    localparam int A_BITS_DEF = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2,
        PUSH  = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/tri_feeder_if.sv
// rtl/tri_feeder_if.sv - ray FIFO, triangle memory and p_hit links of the feeder
interface tri_feeder_if
    import tri_feeder_pkg::*;
#(
    parameter int D_BITS = D_BITS_DEF,
    parameter int M_BITS = M_BITS_DEF,
    parameter int A_BITS = A_BITS_DEF
) ();

    logic [A_BITS:0]              num_tri;
    logic [2:0][D_BITS-1:0]       ray_origin;
    logic [2:0][D_BITS-1:0]       ray_dir;
    logic                         ray_empty;
    logic                         ray_rd_en;

    logic [A_BITS-1:0]            tri_addr;
    logic                         tri_rd_en;
    logic [2:0][D_BITS-1:0]       tri_normal_in;
    logic [2:0][D_BITS-1:0]       v0_in;
    logic [2:0][D_BITS-1:0]       v1_in;
    logic [2:0][D_BITS-1:0]       v2_in;

    logic [2:0][D_BITS-1:0]       out_origin;
    logic [2:0][D_BITS-1:0]       out_dir;
    logic [2:0][D_BITS-1:0]       out_tri_normal;
    logic [2:0][D_BITS-1:0]       out_v0;
    logic [2:0][D_BITS-1:0]       out_v1;
    logic [2:0][D_BITS-1:0]       out_v2;
    logic signed [M_BITS-1:0]     out_triangle_id;
    logic                         out_wr_en;
    logic                         out_full;
    logic                         ray_done;

    modport master (
        input  num_tri, ray_origin, ray_dir, ray_empty,
        output ray_rd_en,
        output tri_addr, tri_rd_en,
        input  tri_normal_in, v0_in, v1_in, v2_in,
        output out_origin, out_dir, out_tri_normal, out_v0, out_v1, out_v2,
        output out_triangle_id, out_wr_en,
        input  out_full,
        output ray_done
    );

    modport slave (
        output num_tri, ray_origin, ray_dir, ray_empty,
        input  ray_rd_en,
        input  tri_addr, tri_rd_en,
        output tri_normal_in, v0_in, v1_in, v2_in,
        input  out_origin, out_dir, out_tri_normal, out_v0, out_v1, out_v2,
        input  out_triangle_id, out_wr_en,
        output out_full,
        input  ray_done
    );

endinterface

// File: rtl/tri_feeder.sv
// rtl/tri_feeder.sv - pops rays and streams each ray's triangles into p_hit
module tri_feeder
    import tri_feeder_pkg::*;
#(
    parameter int D_BITS = D_BITS_DEF,
    parameter int M_BITS = M_BITS_DEF,
    parameter int A_BITS = A_BITS_DEF
) (
    input logic          clock,
    input logic          reset,
    tri_feeder_if.master bus
);

    feeder_state_t          state;
    logic [A_BITS-1:0]      idx;
    logic [A_BITS:0]        num_tri_q;
    logic [2:0][D_BITS-1:0] origin_q;
    logic [2:0][D_BITS-1:0] dir_q;
    logic [2:0][D_BITS-1:0] normal_q;
    logic [2:0][D_BITS-1:0] v0_q;
    logic [2:0][D_BITS-1:0] v1_q;
    logic [2:0][D_BITS-1:0] v2_q;
    logic [M_BITS-1:0]      id_q;
    logic                   done_q;
    logic                   last_tri;

    // num_tri_q is one bit wider than idx so a full 2^A_BITS ray ends at the top address
    assign last_tri = ({1'b0, idx} == (num_tri_q - (A_BITS+1)'(1)));

    // FWFT pop: head data is latched on the same edge that consumes it
    assign bus.ray_rd_en = reset && (state == IDLE) && !bus.ray_empty;
    assign bus.tri_rd_en = (state == FETCH);
    assign bus.tri_addr  = idx;
    assign bus.out_wr_en = (state == PUSH) && !bus.out_full;

    assign bus.out_origin      = origin_q;
    assign bus.out_dir         = dir_q;
    assign bus.out_tri_normal  = normal_q;
    assign bus.out_v0          = v0_q;
    assign bus.out_v1          = v1_q;
    assign bus.out_v2          = v2_q;
    assign bus.out_triangle_id = id_q;
    assign bus.ray_done        = done_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            idx       <= '0;
            num_tri_q <= '0;
            origin_q  <= '0;
            dir_q     <= '0;
            normal_q  <= '0;
            v0_q      <= '0;
            v1_q      <= '0;
            v2_q      <= '0;
            id_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.ray_empty) begin
                        origin_q  <= bus.ray_origin;
                        dir_q     <= bus.ray_dir;
                        num_tri_q <= bus.num_tri;
                        idx       <= '0;
                        if (bus.num_tri == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    state <= LOAD;
                end
                LOAD: begin
                    normal_q <= bus.tri_normal_in;
                    v0_q     <= bus.v0_in;
                    v1_q     <= bus.v1_in;
                    v2_q     <= bus.v2_in;
                    id_q     <= M_BITS'(idx);
                    state    <= PUSH;
                end
                PUSH: begin
                    if (!bus.out_full) begin
                        if (last_tri) begin
                            done_q <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            idx   <= idx + A_BITS'(1);
                            state <= FETCH;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tri_feeder.sv
// tb/tb_tri_feeder.sv - randomized scoreboard bench for tri_feeder
module tb_tri_feeder;
    import tri_feeder_pkg::*;

    localparam int D    = D_BITS_DEF;
    localparam int M    = M_BITS_DEF;
    localparam int A    = A_BITS_DEF;
    localparam int NMEM = 1 << A;

    typedef struct packed {
        logic [95:0] o;
        logic [95:0] d;
        logic [A:0]  n;
    } ray_t;

    typedef struct packed {
        logic [95:0] o;
        logic [95:0] d;
        logic [95:0] nrm;
        logic [95:0] v0;
        logic [95:0] v1;
        logic [95:0] v2;
        logic [31:0] id;
    } exp_t;

    logic clock = 1'b0;
    logic reset;

    tri_feeder_if #(.D_BITS(D), .M_BITS(M), .A_BITS(A)) bus ();

    tri_feeder #(.D_BITS(D), .M_BITS(M), .A_BITS(A)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;

    logic [95:0] mem_n  [NMEM];
    logic [95:0] mem_v0 [NMEM];
    logic [95:0] mem_v1 [NMEM];
    logic [95:0] mem_v2 [NMEM];

    ray_t ray_q [$];
    exp_t exp_q [$];

    int   vectors  = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   push_at  = 0;
    int   done_due = -1;
    int   full_pct = 0;
    logic busy     = 1'b0;
    logic s_pop    = 1'b0;
    logic s_rd     = 1'b0;
    logic [A-1:0] s_addr = '0;

    function automatic logic [95:0] rand96();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string name, input logic [767:0] got, input logic [767:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    task automatic drive_ray();
        if (ray_q.size() != 0) begin
            bus.ray_empty  = 1'b0;
            bus.ray_origin = ray_q[0].o;
            bus.ray_dir    = ray_q[0].d;
            bus.num_tri    = ray_q[0].n;
        end else begin
            bus.ray_empty  = 1'b1;
            bus.ray_origin = rand96();
            bus.ray_dir    = rand96();
            bus.num_tri    = (A+1)'($urandom());
        end
    endtask

    task automatic add_ray(input logic [95:0] o, input logic [95:0] d, input int n);
        ray_t r;
        r.o = o;
        r.d = d;
        r.n = (A+1)'(n);
        ray_q.push_back(r);
        drive_ray();
    endtask

    // memory answers only on the cycle after a read strobe; otherwise it shows noise
    task automatic cycle();
        @(negedge clock);
        s_pop  = bus.ray_rd_en;
        s_rd   = bus.tri_rd_en;
        s_addr = bus.tri_addr;
        @(posedge clock);
        #1;
        if (s_pop && ray_q.size() != 0) void'(ray_q.pop_front());
        drive_ray();
        if (s_rd) begin
            bus.tri_normal_in = mem_n[s_addr];
            bus.v0_in         = mem_v0[s_addr];
            bus.v1_in         = mem_v1[s_addr];
            bus.v2_in         = mem_v2[s_addr];
        end else begin
            bus.tri_normal_in = rand96();
            bus.v0_in         = rand96();
            bus.v1_in         = rand96();
            bus.v2_in         = rand96();
        end
        bus.out_full = (int'($urandom_range(0, 99)) < full_pct);
    endtask

    task automatic drain(input int bound);
        int b = 0;
        while ((ray_q.size() != 0 || busy || done_due > cyc) && b < bound) begin
            cycle();
            b++;
        end
        if (b >= bound) begin
            vectors++;
            errors++;
            $display("FAIL drain_timeout cyc=%0d got=busy exp=idle", cyc);
        end
    endtask

    // reference: each popped ray yields num_tri writes; the first PUSH opportunity is 3 cycles
    // after the pop, each later one 3 cycles after the previous write, and a write lands on
    // the first cycle in that window where out_full is low
    always @(negedge clock) begin
        logic exp_pop;
        logic exp_rd;
        logic exp_wr;
        int   n;
        exp_t e;
        cyc++;
        if (!reset) begin
            chk("reset_zero", {bus.ray_rd_en, bus.tri_rd_en, bus.out_wr_en, bus.ray_done,
                               bus.tri_addr, bus.out_origin, bus.out_dir, bus.out_tri_normal,
                               bus.out_v0, bus.out_v1, bus.out_v2, bus.out_triangle_id}, '0);
            exp_q.delete();
            busy     = 1'b0;
            done_due = -1;
        end else begin
            exp_pop = !busy && !bus.ray_empty;
            chk("ray_done", bus.ray_done, cyc == done_due);
            exp_rd = busy && (cyc == push_at - 2);
            chk("tri_rd_en", bus.tri_rd_en, exp_rd);
            if (exp_rd) chk("tri_addr", bus.tri_addr, exp_q[0].id);
            if (busy && cyc >= push_at) begin
                chk("out_data", {bus.out_origin, bus.out_dir, bus.out_tri_normal, bus.out_v0,
                                 bus.out_v1, bus.out_v2, bus.out_triangle_id}, exp_q[0]);
                exp_wr = !bus.out_full;
                chk("out_wr_en", bus.out_wr_en, exp_wr);
                if (exp_wr) begin
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) begin
                        busy     = 1'b0;
                        done_due = cyc + 1;
                    end else begin
                        push_at = cyc + 3;
                    end
                end
            end else begin
                chk("out_wr_en_idle", bus.out_wr_en, 1'b0);
            end
            chk("ray_rd_en", bus.ray_rd_en, exp_pop);
            if (exp_pop) begin
                n = int'(bus.num_tri);
                if (n == 0) begin
                    done_due = cyc + 1;
                end else begin
                    busy    = 1'b1;
                    push_at = cyc + 3;
                    for (int i = 0; i < n; i++) begin
                        e.o   = bus.ray_origin;
                        e.d   = bus.ray_dir;
                        e.nrm = mem_n[i];
                        e.v0  = mem_v0[i];
                        e.v1  = mem_v1[i];
                        e.v2  = mem_v2[i];
                        e.id  = 32'(i);
                        exp_q.push_back(e);
                    end
                end
            end
        end
    end

    initial begin
        int b;
        for (int i = 0; i < NMEM; i++) begin
            mem_n[i]  = rand96();
            mem_v0[i] = rand96();
            mem_v1[i] = rand96();
            mem_v2[i] = rand96();
        end
        reset             = 1'b1;
        bus.out_full      = 1'b0;
        bus.tri_normal_in = rand96();
        bus.v0_in         = rand96();
        bus.v1_in         = rand96();
        bus.v2_in         = rand96();
        drive_ray();
        #2 reset = 1'b0;
        repeat (3) cycle();
        #1 reset = 1'b1;
        repeat (2) cycle();

        add_ray(rand96(), rand96(), 3);
        drain(100);
        add_ray(rand96(), rand96(), 0);
        drain(100);
        add_ray({32'd0, 32'd0, 32'h0001_0000}, rand96(), 2);
        add_ray({32'd0, 32'h0002_0000, 32'd0}, rand96(), 2);
        drain(100);

        full_pct = 100;
        add_ray(rand96(), rand96(), 1);
        repeat (9) cycle();
        full_pct = 0;
        drain(100);

        full_pct = 30;
        for (int r = 0; r < 40; r++) begin
            add_ray(rand96(), rand96(), int'($urandom_range(0, 6)));
            repeat ($urandom_range(0, 8)) cycle();
        end
        drain(2000);

        full_pct = 10;
        add_ray(rand96(), rand96(), NMEM);
        drain(6000);

        full_pct = 0;
        add_ray(rand96(), rand96(), 4);
        add_ray(rand96(), rand96(), 2);
        b = 0;
        do begin
            cycle();
            b++;
        end while (!(s_rd && s_addr == A'(1)) && b < 40);
        if (!(s_rd && s_addr == A'(1))) begin
            vectors++;
            errors++;
            $display("FAIL wait_fetch_id1 cyc=%0d got=%0d exp=1", cyc, s_addr);
        end
        #1 reset = 1'b0;
        repeat (2) cycle();
        #1 reset = 1'b1;
        drain(200);

        repeat (3) cycle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/tri_feeder.md
TRI_FEEDER -- requirements
Module: tri_feeder

Interface
REQ-001 SHALL have parameter D_BITS, default 32, fixed-point coordinate width.
REQ-002 SHALL have parameter M_BITS, default 32, triangle-id width.
REQ-003 SHALL have parameter A_BITS, default 10, triangle-memory address width.
REQ-004 SHALL have port clock  in  1  sole clock, all logic rising-edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port num_tri  in  A_BITS+1  triangle count per ray, sampled at ray pop.
REQ-007 SHALL have port ray_origin  in  D_BITS x3 signed [2:0]  head-of-ray-FIFO origin.
REQ-008 SHALL have port ray_dir  in  D_BITS x3 signed [2:0]  head-of-ray-FIFO direction.
REQ-009 SHALL have port ray_empty  in  1  ray FIFO empty (first-word-fall-through).
REQ-010 SHALL have port ray_rd_en  out  1  pops ray FIFO.
REQ-011 SHALL have port tri_addr  out  A_BITS  triangle memory read address.
REQ-012 SHALL have port tri_rd_en  out  1  memory read strobe, data valid next cycle.
REQ-013 SHALL have port tri_normal_in  in  D_BITS x3 signed  memory read data, normal.
REQ-014 SHALL have port v0_in  in  D_BITS x3 signed  memory read data, vertex 0.
REQ-015 SHALL have port v1_in  in  D_BITS x3 signed  memory read data, vertex 1.
REQ-016 SHALL have port v2_in  in  D_BITS x3 signed  memory read data, vertex 2.
REQ-017 SHALL have port out_origin  out  D_BITS x3 signed  origin to p_hit.
REQ-018 SHALL have port out_dir  out  D_BITS x3 signed  direction to p_hit.
REQ-019 SHALL have port out_tri_normal  out  D_BITS x3 signed  normal to p_hit.
REQ-020 SHALL have port out_v0  out  D_BITS x3 signed  vertex 0 to p_hit.
REQ-021 SHALL have port out_v1  out  D_BITS x3 signed  vertex 1 to p_hit.
REQ-022 SHALL have port out_v2  out  D_BITS x3 signed  vertex 2 to p_hit.
REQ-023 SHALL have port out_triangle_id  out  M_BITS signed  index, zero-extended.
REQ-024 SHALL have port out_wr_en  out  1  write strobe into p_hit in_wr_en.
REQ-025 SHALL have port out_full  in  1  p_hit in_full backpressure.
REQ-026 SHALL have port ray_done  out  1  one-cycle pulse after last triangle of a ray written.

Function
REQ-027 SHALL implement states IDLE, FETCH, LOAD, PUSH.
REQ-028 IDLE: when !ray_empty, SHALL assert ray_rd_en one cycle, latch origin/dir/num_tri, clear idx; go FETCH if num_tri!=0, else pulse ray_done next cycle and stay IDLE.
REQ-029 FETCH: SHALL assert tri_rd_en with tri_addr=idx for exactly one cycle, then LOAD.
REQ-030 LOAD: SHALL capture tri_normal_in/v0_in/v1_in/v2_in into output holding registers, out_triangle_id=idx, then PUSH.
REQ-031 PUSH: out_wr_en SHALL equal !out_full (combinational); outputs held stable while out_full=1, no cycle limit.
REQ-032 On write in PUSH: if idx==num_tri-1 SHALL pulse ray_done next cycle and go IDLE, else idx+=1 and go FETCH.
REQ-033 Latency: ray pop at cycle N -> first out_wr_en at N+3 if !out_full; steady throughput one triangle per 3 cycles.
REQ-034 SHALL never assert ray_rd_en outside IDLE, nor when ray_empty=1.
REQ-035 SHALL never assert tri_rd_en and out_wr_en in the same cycle.
REQ-036 num_tri changes mid-ray SHALL be ignored; max num_tri=2^A_BITS addresses 0..2^A_BITS-1 without wrap.
REQ-037 out_origin/out_dir SHALL remain constant across all triangles of one ray.

Reset
REQ-038 On reset low SHALL asynchronously go IDLE, idx=0, all data outputs 0, ray_rd_en/tri_rd_en/out_wr_en/ray_done=0; mid-ray reset abandons the ray with no further writes.

Structure
REQ-039 Shared package SHALL hold D_BITS/M_BITS defaults and the feeder state enum typedef.
REQ-040 SHALL be one flat module; no sub-module is warranted.

Verification
REQ-041 One ray, num_tri=3, out_full=0 -> three writes at N+3, N+6, N+9 with ids 0,1,2, ray_done at N+10.
REQ-042 num_tri=0 with ray present -> one ray_rd_en, ray_done next cycle, zero out_wr_en, zero tri_rd_en.
REQ-043 out_full held high 5 cycles in PUSH -> out_wr_en=0, outputs unchanged, single write on release.
REQ-044 Two queued rays, num_tri=2, origins (1.0,0,0)/(0,2.0,0) Q16 -> four writes, origin switches only after first ray_done.
REQ-045 Reset asserted in LOAD of id 1 of 4 -> all outputs 0 immediately, no write for id 1, next ray starts at id 0.
